pattern_pwm: RTL and testbench
==============================

PATTERN_PWM -- requirements
Module: pattern_pwm

Interface
REQ-001 SHALL have parameter _PAT_WIDTH, default 16, giving the pattern register width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-high reset (1 = reset), named as in the codebase.
REQ-004 SHALL have port pwm_en, input, 1 bit; its rising edge starts a sequence and its falling edge stops one.
REQ-005 SHALL have port duty_num, input, 8 bits, giving the clocks per pattern bit (slot length).
REQ-006 SHALL have port pulse_dessert, input, 16 bits, giving the low gap in clocks after each pattern pass.
REQ-007 SHALL have port pulse_num, input, 8 bits, giving the number of pattern passes (0 = infinite).
REQ-008 SHALL have port PAT, input, _PAT_WIDTH bits, holding the output pattern, sent LSB first.
REQ-009 SHALL have port pwm_out, output, 1 bit, the registered pattern output.
REQ-010 SHALL have port busy, output, 1 bit, high while a sequence is running.
REQ-011 SHALL have port valid, output, 1 bit, a one-clock pulse at sequence end.

Function
REQ-012 SHALL register pwm_en into pwm_en_d and detect rise as pwm_en & ~pwm_en_d and fall as ~pwm_en & pwm_en_d.
REQ-013 SHALL use FSM states IDLE, PATTERN, GAP, DONE.
REQ-014 SHALL, in IDLE on a rise, latch duty_num, pulse_dessert, pulse_num and PAT and enter PATTERN; input changes during a run are ignored.
REQ-015 SHALL treat a latched duty_num of 0 as 1.
REQ-016 SHALL, in PATTERN, drive pwm_out = PAT[i] for duty_num clocks per bit, with i going from 0 to _PAT_WIDTH-1.
REQ-017 SHALL go from PATTERN to GAP after the last bit, with pwm_out = 0 for pulse_dessert clocks; if pulse_dessert is 0, GAP is skipped.
REQ-018 SHALL, at the end of a pass, increment the 8-bit pass counter; DONE is entered when the count equals a nonzero pulse_num, otherwise PATTERN restarts at bit 0.
REQ-019 SHALL, when pulse_num is 0, repeat passes until a fall is detected.
REQ-020 SHALL, on a fall in PATTERN or GAP (any mode), abort immediately and enter DONE.
REQ-021 SHALL, in DONE, hold pwm_out = 0, busy = 0 and valid = 1 for exactly one clock, then go to IDLE.
REQ-022 SHALL keep busy = 1 in PATTERN and GAP only; pwm_out is 0 outside PATTERN.
REQ-023 SHALL register all outputs, so the first PAT[0] slot and busy = 1 appear one clock after the edge that samples the rise.
REQ-024 SHALL require a fresh rise to start again; pwm_en held high after DONE does not retrigger.
REQ-025 SHALL ignore a rise outside IDLE and a fall in IDLE or DONE.

Reset
REQ-026 SHALL, while rst_n = 1, asynchronously force state IDLE, pwm_out = 0, busy = 0, valid = 0 and pwm_en_d = 0, and clear all counters and latched fields.
REQ-027 SHALL, on reset mid-run, abandon the run without a valid pulse.
REQ-028 SHALL, after reset release, not count a pwm_en that is already high as a rise until pwm_en_d has sampled it.

Structure
REQ-029 SHALL put the FSM state enum and counter-width constants in a shared package, pattern_pwm_pkg.
REQ-030 SHALL be a single module with no sub-modules; counters are an 8-bit slot counter, a $clog2(_PAT_WIDTH) bit index, a 16-bit gap counter and an 8-bit pass counter.

Verification
REQ-031 SHALL cover: duty_num = 1, pulse_dessert = 16, pulse_num = 2, PAT = 0x00AA, pwm_en high -> per pass pwm_out 0,1,0,1,0,1,0,1 then 24 clocks low; busy high 64 clocks; valid one pulse.
REQ-032 SHALL cover: duty_num = 2, pulse_dessert = 21, pulse_num = 3, PAT = 0x00FF -> per pass 16 clocks high then 37 low; busy high 159 clocks; valid once.
REQ-033 SHALL cover: duty_num = 1, pulse_dessert = 5, pulse_num = 0, PAT = 0x001F, pwm_en dropped after 50 clocks -> 5 high / 16 low repeating until the fall; the clock after the fall is sampled gives pwm_out = 0, busy = 0, valid = 1.
REQ-034 SHALL cover: rst_n pulsed high mid-pass -> pwm_out, busy and valid go 0 at once; no valid afterwards.
REQ-035 SHALL cover: pwm_en held high past DONE with duty_num = 0 -> slots are 1 clock; exactly one run and no restart.

Source files
------------

// File: rtl/pattern_pwm_pkg.sv
// Shared FSM encoding and counter widths for the pattern PWM generator.
package pattern_pwm_pkg;

  localparam int unsigned SLOT_W = 8;   // clocks per pattern bit
  localparam int unsigned GAP_W  = 16;  // clocks of low gap after a pass
  localparam int unsigned PASS_W = 8;   // number of pattern passes

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PATTERN = 2'd1,
    GAP     = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage : pattern_pwm_pkg

// File: rtl/pattern_pwm.sv
// Pattern PWM generator: plays a latched bit pattern LSB first, each bit held
// for duty_num clocks, followed by a low gap, for pulse_num passes (0 = until
// pwm_en falls). All outputs are registered alongside the FSM state.
module pattern_pwm
  import pattern_pwm_pkg::*;
#(
  parameter int unsigned _PAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_en,
  input  logic [SLOT_W-1:0]     duty_num,
  input  logic [GAP_W-1:0]      pulse_dessert,
  input  logic [PASS_W-1:0]     pulse_num,
  input  logic [_PAT_WIDTH-1:0] PAT,
  output logic                  pwm_out,
  output logic                  busy,
  output logic                  valid
);

  localparam int unsigned     IDX_W    = $clog2(_PAT_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(_PAT_WIDTH - 1);

  state_t                  state, state_next;
  logic                    pwm_en_d;
  logic [SLOT_W-1:0]       duty_q, duty_next;
  logic [GAP_W-1:0]        gap_len_q, gap_len_next;
  logic [PASS_W-1:0]       pass_num_q, pass_num_next;
  logic [_PAT_WIDTH-1:0]   pat_q, pat_next;
  logic [SLOT_W-1:0]       slot_cnt, slot_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [GAP_W-1:0]        gap_cnt, gap_next;
  logic [PASS_W-1:0]       pass_cnt, pass_next;
  logic                    pwm_next, busy_next, valid_next;
  logic                    pass_end;
  logic                    rise, fall;

  assign rise = pwm_en & ~pwm_en_d;
  assign fall = ~pwm_en & pwm_en_d;

  // State, counters, latched run parameters and registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      pwm_en_d   <= 1'b0;
      duty_q     <= '0;
      gap_len_q  <= '0;
      pass_num_q <= '0;
      pat_q      <= '0;
      slot_cnt   <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      pass_cnt   <= '0;
      pwm_out    <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      state      <= state_next;
      pwm_en_d   <= pwm_en;
      duty_q     <= duty_next;
      gap_len_q  <= gap_len_next;
      pass_num_q <= pass_num_next;
      pat_q      <= pat_next;
      slot_cnt   <= slot_next;
      idx        <= idx_next;
      gap_cnt    <= gap_next;
      pass_cnt   <= pass_next;
      pwm_out    <= pwm_next;
      busy       <= busy_next;
      valid      <= valid_next;
    end
  end

  // Next-state, counter updates and next output values.
  always_comb begin
    state_next    = state;
    duty_next     = duty_q;
    gap_len_next  = gap_len_q;
    pass_num_next = pass_num_q;
    pat_next      = pat_q;
    slot_next     = slot_cnt;
    idx_next      = idx;
    gap_next      = gap_cnt;
    pass_next     = pass_cnt;
    pwm_next      = 1'b0;
    busy_next     = 1'b0;
    valid_next    = 1'b0;
    pass_end      = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_next    = PATTERN;
          // A zero slot length is treated as a single clock per bit.
          duty_next     = (duty_num == '0) ? SLOT_W'(1) : duty_num;
          gap_len_next  = pulse_dessert;
          pass_num_next = pulse_num;
          pat_next      = PAT;
          slot_next     = '0;
          idx_next      = '0;
          gap_next      = '0;
          pass_next     = '0;
          pwm_next      = PAT[0];
          busy_next     = 1'b1;
        end
      end

      PATTERN: begin
        busy_next = 1'b1;
        if (fall) begin
          state_next = DONE;
          busy_next  = 1'b0;
          valid_next = 1'b1;
        end else if (slot_cnt == duty_q - SLOT_W'(1)) begin
          slot_next = '0;
          if (idx == LAST_IDX) begin
            if (gap_len_q != '0) begin
              state_next = GAP;
              gap_next   = '0;
            end else begin
              pass_end = 1'b1;
            end
          end else begin
            idx_next = IDX_W'(idx + 1'b1);
            pwm_next = pat_q[idx_next];
          end
        end else begin
          slot_next = SLOT_W'(slot_cnt + 1'b1);
          pwm_next  = pat_q[idx];
        end
      end

      GAP: begin
        busy_next = 1'b1;
        if (fall) begin
          state_next = DONE;
          busy_next  = 1'b0;
          valid_next = 1'b1;
        end else if (gap_cnt == gap_len_q - GAP_W'(1)) begin
          pass_end = 1'b1;
        end else begin
          gap_next = GAP_W'(gap_cnt + 1'b1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // End of a pass: either finish the run or restart the pattern at bit 0.
    if (pass_end) begin
      pass_next = PASS_W'(pass_cnt + 1'b1);
      if ((pass_num_q != '0) && (pass_next == pass_num_q)) begin
        state_next = DONE;
        busy_next  = 1'b0;
        valid_next = 1'b1;
        pwm_next   = 1'b0;
      end else begin
        state_next = PATTERN;
        busy_next  = 1'b1;
        idx_next   = '0;
        slot_next  = '0;
        pwm_next   = pat_q[0];
      end
    end
  end

endmodule : pattern_pwm

// File: tb/tb_pattern_pwm.sv
// Self-checking bench for pattern_pwm: a reference model pushes the expected
// per-clock {pwm_out, busy, valid} into a queue, popped as the DUT runs.
module tb_pattern_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_en;
  logic [7:0]  duty_num;
  logic [15:0] pulse_dessert;
  logic [7:0]  pulse_num;
  logic [15:0] PAT;
  logic        pwm_out, busy, valid;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];

  localparam logic [2:0] E_IDLE = 3'b000;
  localparam logic [2:0] E_GAP  = 3'b010;
  localparam logic [2:0] E_DONE = 3'b001;

  pattern_pwm #(._PAT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_en        (pwm_en),
    .duty_num      (duty_num),
    .pulse_dessert (pulse_dessert),
    .pulse_num     (pulse_num),
    .PAT           (PAT),
    .pwm_out       (pwm_out),
    .busy          (busy),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: pwm/busy/valid got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [2:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // One full pass: every bit for max(duty,1) clocks, then the gap.
  task automatic push_pass(input logic [15:0] pat, input logic [7:0] duty, input int gap_len);
    int d;
    d = (duty == 8'd0) ? 1 : int'(duty);
    for (int i = 0; i < 16; i++)
      repeat (d) exp_q.push_back({pat[i], 1'b1, 1'b0});
    push_n(E_GAP, gap_len);
  endtask

  task automatic config_run(input logic [7:0] d, input logic [15:0] g,
                            input logic [7:0] n, input logic [15:0] p);
    duty_num      = d;
    pulse_dessert = g;
    pulse_num     = n;
    PAT           = p;
  endtask

  // Raise pwm_en, drain the queue one clock per entry, optionally drop
  // pwm_en after drop_at clocks; inputs are scrambled once the run has latched.
  task automatic run(input string tag, input int drop_at, input bit release_en,
                     input int exp_busy, input int exp_valid);
    int ticks = 0;
    int bcnt  = 0;
    int vcnt  = 0;
    logic [2:0] e;
    pwm_en = 1'b1;
    while (exp_q.size() > 0) begin
      if (ticks == drop_at) pwm_en = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, {pwm_out, busy, valid}, e);
      bcnt += int'(busy);
      vcnt += int'(valid);
      if (ticks == 1) begin
        duty_num      = 8'($urandom);
        pulse_dessert = 16'($urandom);
        pulse_num     = 8'($urandom);
        PAT           = 16'($urandom);
      end
      ticks++;
      @(posedge clk); #1;
    end
    if (release_en) begin
      pwm_en = 1'b0;
      @(posedge clk); #1;
    end
    check_cnt({tag, "_busy_clocks"}, bcnt, exp_busy);
    check_cnt({tag, "_valid_pulses"}, vcnt, exp_valid);
  endtask

  initial begin
    rst_n  = 1'b1;
    pwm_en = 1'b0;
    config_run(8'd0, 16'd0, 8'd0, 16'd0);
    #7;
    check("reset_state", {pwm_out, busy, valid}, E_IDLE);
    #5 rst_n = 1'b0;
    @(posedge clk); #1;

    // Alternating pattern, two passes, 16-clock gap.
    config_run(8'd1, 16'd16, 8'd2, 16'h00AA);
    push_n(E_IDLE, 1);
    push_pass(16'h00AA, 8'd1, 16);
    push_pass(16'h00AA, 8'd1, 16);
    push_n(E_DONE, 1);
    push_n(E_IDLE, 3);
    run("aa_x2", -1, 1'b1, 64, 1);

    // Two-clock slots, three passes.
    config_run(8'd2, 16'd21, 8'd3, 16'h00FF);
    push_n(E_IDLE, 1);
    repeat (3) push_pass(16'h00FF, 8'd2, 21);
    push_n(E_DONE, 1);
    push_n(E_IDLE, 3);
    run("ff_x3", -1, 1'b1, 159, 1);

    // Infinite mode, aborted by pwm_en falling after 50 clocks.
    config_run(8'd1, 16'd5, 8'd0, 16'h001F);
    push_n(E_IDLE, 1);
    push_pass(16'h001F, 8'd1, 5);
    push_pass(16'h001F, 8'd1, 5);
    push_n(3'b110, 5);
    push_n(E_GAP, 3);
    push_n(E_DONE, 1);
    push_n(E_IDLE, 3);
    run("inf_abort", 50, 1'b1, 50, 1);

    // No gap: passes run back to back.
    config_run(8'd3, 16'd0, 8'd2, 16'h1234);
    push_n(E_IDLE, 1);
    push_pass(16'h1234, 8'd3, 0);
    push_pass(16'h1234, 8'd3, 0);
    push_n(E_DONE, 1);
    push_n(E_IDLE, 2);
    run("no_gap", -1, 1'b1, 96, 1);

    // Reset pulsed mid-pass: outputs clear at once, no valid follows.
    config_run(8'd1, 16'd2, 8'd0, 16'h0F0F);
    push_n(E_IDLE, 1);
    for (int i = 0; i < 10; i++) exp_q.push_back({(i < 4) || (i > 7), 1'b1, 1'b0});
    run("pre_reset", -1, 1'b0, 10, 0);
    #2 rst_n = 1'b1;
    #1 check("reset_mid_run", {pwm_out, busy, valid}, E_IDLE);
    pwm_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    push_n(E_IDLE, 6);
    begin
      int vcnt = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("post_reset", {pwm_out, busy, valid}, exp_q.pop_front());
        vcnt += int'(valid);
      end
      check_cnt("post_reset_valid", vcnt, 0);
    end
    @(posedge clk); #1;

    // duty_num 0 acts as 1; pwm_en held high past DONE does not restart.
    config_run(8'd0, 16'd3, 8'd1, 16'h8001);
    push_n(E_IDLE, 1);
    push_pass(16'h8001, 8'd0, 3);
    push_n(E_DONE, 1);
    push_n(E_IDLE, 10);
    run("hold_high", -1, 1'b1, 19, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pattern_pwm
